// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a FIFO with 1-cycle read latency into a
// valid/ready output stream through a 2-entry in-order skid buffer.
// Reads are issued only when the buffer is sure to have room for the
// word, so no word is ever dropped and nothing backs up into the FIFO.
//
// Handshake: a word transfers on every rclk edge where m_valid=1 and
// m_ready=1. Once m_valid is high it stays high, and m_data stays
// unchanged, until that transfer happens. m_valid never depends
// combinationally on m_ready.
module fifo_rd_stream #(
  parameter int DW = 4,
  parameter int CW = 8
) (
  input  logic          rclk,
  input  logic          rst_i,
  input  logic          en,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_dat,
  output logic          fifo_ren,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready,
  output logic          busy,
  output logic [CW-1:0] rd_cnt
);

  // Buffer occupancy; encoding equals the number of words held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e          state_q;
  occ_e          state_d;
  logic          pend_q;
  logic [DW-1:0] head_q;
  logic [DW-1:0] head_d;
  logic [DW-1:0] tail_q;
  logic [DW-1:0] tail_d;
  logic          hs;
  logic [1:0]    occ_num;
  logic [2:0]    fill_after;

  assign m_valid = (state_q != EMPTY);
  assign m_data  = head_q;
  assign hs      = m_valid & m_ready;
  assign busy    = pend_q | m_valid;

  // Read issue: words held after this edge (buffered + in flight - leaving)
  // must stay below 2, so a word read now always has a slot next cycle.
  always_comb begin
    occ_num    = state_q;
    fill_after = {1'b0, occ_num} + {2'b00, pend_q} - {2'b00, hs};
    fifo_ren   = !rst_i & en & !fifo_empty & (fill_after < 3'd2);
  end

  // Next occupancy and buffer contents: capture on pend, advance on hs.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case ({pend_q, hs})
      2'b10: begin
        if (state_q == EMPTY) begin
          head_d  = fifo_dat;
          state_d = ONE;
        end else begin
          tail_d  = fifo_dat;
          state_d = TWO;
        end
      end
      2'b01: begin
        if (state_q == TWO) begin
          head_d  = tail_q;
          state_d = ONE;
        end else begin
          state_d = EMPTY;
        end
      end
      2'b11: begin
        // Head leaves and the arriving word queues behind whatever remains.
        if (state_q == TWO) begin
          head_d = tail_q;
          tail_d = fifo_dat;
        end else begin
          head_d = fifo_dat;
        end
      end
      default: begin
      end
    endcase
  end

  // State registers; reset discards buffered and in-flight words.
  always_ff @(posedge rclk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      pend_q  <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      rd_cnt  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= fifo_ren;
      head_q  <= head_d;
      tail_q  <= tail_d;
      if (hs) begin
        rd_cnt <= rd_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: directed cycle tables, reset corners, a CW=2
// counter wrap instance, and a randomized run against an ordering model.
module tb_fifo_rd_stream;
  localparam int DW = 4;
  localparam int CW = 8;

  // ---------------- clock / reset / signals ----------------
  logic          rclk = 1'b0;
  logic          rst_i;
  logic          en;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dat;
  logic          m_ready;
  logic          fifo_ren;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          busy;
  logic [CW-1:0] rd_cnt;
  logic          fifo_ren2;
  logic          m_valid2;
  logic [DW-1:0] m_data2;
  logic          busy2;
  logic [1:0]    rd_cnt2;

  always #5 rclk = ~rclk;

  fifo_rd_stream #(.DW(DW), .CW(CW)) dut (
    .rclk(rclk), .rst_i(rst_i), .en(en), .fifo_empty(fifo_empty),
    .fifo_dat(fifo_dat), .fifo_ren(fifo_ren), .m_valid(m_valid),
    .m_data(m_data), .m_ready(m_ready), .busy(busy), .rd_cnt(rd_cnt)
  );

  // Narrow-counter instance sharing all inputs, for the wrap check.
  fifo_rd_stream #(.DW(DW), .CW(2)) dut2 (
    .rclk(rclk), .rst_i(rst_i), .en(en), .fifo_empty(fifo_empty),
    .fifo_dat(fifo_dat), .fifo_ren(fifo_ren2), .m_valid(m_valid2),
    .m_data(m_data2), .m_ready(m_ready), .busy(busy2), .rd_cnt(rd_cnt2)
  );

  // ---------------- FIFO model (1-cycle registered read) ----------------
  logic [DW-1:0] fifo_mem [0:4095];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          ren_s = 1'b0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  // Scoreboard: every word popped from the FIFO must come out, in order.
  logic [DW-1:0] exp_q[$];
  logic [CW-1:0] model_cnt = '0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [DW-1:0] v);
    fifo_mem[wr_ptr % 4096] = v;
    wr_ptr++;
  endtask

  always @(posedge rclk) begin
    if (ren_s) begin
      exp_q.push_back(fifo_mem[rd_ptr % 4096]);
      fifo_dat <= fifo_mem[rd_ptr % 4096];
      rd_ptr   <= rd_ptr + 1;
    end else begin
      fifo_dat <= DW'($urandom);
    end
  end

  // Monitor: sampled at negedge, i.e. the values the next rising edge sees.
  always @(negedge rclk) begin
    logic [DW-1:0] e;
    ren_s = fifo_ren;
    if (rst_i) begin
      prev_stall = 1'b0;
    end else begin
      if (fifo_empty) begin
        chk("ren_while_empty", {31'b0, fifo_ren}, 32'd0);
        chk("ren2_while_empty", {31'b0, fifo_ren2}, 32'd0);
      end
      chk("busy", {31'b0, busy}, {31'b0, exp_q.size() != 0});
      chk("busy2", {31'b0, busy2}, {31'b0, exp_q.size() != 0});
      chk("no_overflow", {31'b0, exp_q.size() > 2}, 32'd0);
      chk("rd_cnt", {24'b0, rd_cnt}, {24'b0, model_cnt});
      chk("rd_cnt2", {30'b0, rd_cnt2}, {30'b0, model_cnt[1:0]});
      if (prev_stall) begin
        chk("stall_valid", {31'b0, m_valid}, 32'd1);
        chk("stall_data", {28'b0, m_data}, {28'b0, prev_data});
      end
      if (m_valid2 && exp_q.size() == 0) begin
        chk("valid2_without_word", 32'd1, 32'd0);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("hs_without_word", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("hs_data", {28'b0, m_data}, {28'b0, e});
          chk("hs_data2", {28'b0, m_data2}, {28'b0, e});
        end
        model_cnt = model_cnt + 8'd1;
      end
      prev_stall = m_valid & !m_ready;
      prev_data  = m_data;
    end
  end

  // ---------------- driver tasks ----------------
  typedef struct {
    logic       en;
    logic       rdy;
    logic       ren;
    logic       vld;
    logic [3:0] dat;
    logic       bsy;
    logic [7:0] cnt;
  } vec_t;

  function automatic vec_t mk(input logic e, input logic r, input logic rn,
                              input logic vl, input logic [3:0] d,
                              input logic b, input logic [7:0] c);
    vec_t v;
    v.en = e; v.rdy = r; v.ren = rn; v.vld = vl; v.dat = d; v.bsy = b; v.cnt = c;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    @(posedge rclk); #1;
    en      = v.en;
    m_ready = v.rdy;
    @(negedge rclk);
    chk({nm, "_ren"}, {31'b0, fifo_ren}, {31'b0, v.ren});
    chk({nm, "_vld"}, {31'b0, m_valid}, {31'b0, v.vld});
    if (v.vld) chk({nm, "_dat"}, {28'b0, m_data}, {28'b0, v.dat});
    chk({nm, "_bsy"}, {31'b0, busy}, {31'b0, v.bsy});
    chk({nm, "_cnt"}, {24'b0, rd_cnt}, {24'b0, v.cnt});
  endtask

  task automatic do_reset();
    @(posedge rclk); #1;
    rst_i   = 1'b1;
    en      = 1'b0;
    m_ready = 1'b0;
    wr_ptr  = rd_ptr;
    #1;
    chk("rst_valid", {31'b0, m_valid}, 32'd0);
    chk("rst_data", {28'b0, m_data}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ren", {31'b0, fifo_ren}, 32'd0);
    chk("rst_cnt", {24'b0, rd_cnt}, 32'd0);
    exp_q.delete();
    model_cnt = '0;
    repeat (2) @(posedge rclk);
    #1 rst_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  vec_t t30[6];
  vec_t t31[10];
  vec_t t32[5];
  vec_t t33[6];

  initial begin
    int seq_exp[5];
    int got[$];
    bit hs_prev;
    bit found;
    int limit;
    bit done;

    //           en rdy ren vld dat bsy cnt
    t30[0] = mk(1, 1, 1, 0, 0, 0, 0);
    t30[1] = mk(1, 1, 1, 0, 0, 1, 0);
    t30[2] = mk(1, 1, 1, 1, 3, 1, 0);
    t30[3] = mk(1, 1, 0, 1, 5, 1, 1);
    t30[4] = mk(1, 1, 0, 1, 9, 1, 2);
    t30[5] = mk(1, 1, 0, 0, 0, 0, 3);

    t31[0] = mk(1, 0, 1, 0, 0, 0, 0);
    t31[1] = mk(1, 0, 1, 0, 0, 1, 0);
    t31[2] = mk(1, 0, 0, 1, 1, 1, 0);
    t31[3] = mk(1, 0, 0, 1, 1, 1, 0);
    t31[4] = mk(1, 0, 0, 1, 1, 1, 0);
    t31[5] = mk(1, 1, 1, 1, 1, 1, 0);
    t31[6] = mk(1, 1, 1, 1, 2, 1, 1);
    t31[7] = mk(1, 1, 0, 1, 3, 1, 2);
    t31[8] = mk(1, 1, 0, 1, 4, 1, 3);
    t31[9] = mk(1, 1, 0, 0, 0, 0, 4);

    t32[0] = mk(1, 1, 1, 0, 0, 0, 0);
    t32[1] = mk(0, 1, 0, 0, 0, 1, 0);
    t32[2] = mk(0, 1, 0, 1, 7, 1, 0);
    t32[3] = mk(0, 1, 0, 0, 0, 0, 1);
    t32[4] = mk(0, 1, 0, 0, 0, 0, 1);

    for (int i = 0; i < 6; i++) t33[i] = mk(1, i[0], 0, 0, 0, 0, 0);

    seq_exp = '{1, 2, 3, 0, 1};

    rst_i   = 1'b1;
    en      = 1'b0;
    m_ready = 1'b0;

    // Streaming at full rate.
    do_reset();
    push(4'd3); push(4'd5); push(4'd9);
    for (int i = 0; i < 6; i++) run_vec(t30[i], $sformatf("stream[%0d]", i));

    // Backpressure fills the buffer, then releases without gaps.
    do_reset();
    push(4'd1); push(4'd2); push(4'd3); push(4'd4);
    for (int i = 0; i < 10; i++) run_vec(t31[i], $sformatf("bp[%0d]", i));

    // en dropped right after a pop: in-flight word still delivered.
    do_reset();
    push(4'd7); push(4'd8);
    for (int i = 0; i < 5; i++) run_vec(t32[i], $sformatf("en_drop[%0d]", i));

    // Empty FIFO: nothing is read or produced.
    do_reset();
    for (int i = 0; i < 6; i++) run_vec(t33[i], $sformatf("empty[%0d]", i));

    // Narrow counter wraps 1,2,3,0,1.
    do_reset();
    for (int i = 0; i < 5; i++) push(DW'($urandom));
    @(posedge rclk); #1;
    en = 1'b1; m_ready = 1'b1;
    hs_prev = 1'b0;
    for (int i = 0; i < 30 && got.size() < 5; i++) begin
      @(negedge rclk);
      if (hs_prev) got.push_back(int'(rd_cnt2));
      hs_prev = m_valid & m_ready;
    end
    chk("wrap_len", got.size(), 32'd5);
    for (int i = 0; i < got.size(); i++) chk($sformatf("wrap[%0d]", i), got[i], seq_exp[i]);

    // Reset with one word buffered and one in flight.
    do_reset();
    push(4'd10); push(4'd11); push(4'd12);
    @(posedge rclk); #1; en = 1'b1; m_ready = 1'b0;
    @(posedge rclk); #1;
    @(posedge rclk); #1;
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    rst_i = 1'b1;
    #1;
    chk("midrst_valid", {31'b0, m_valid}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_cnt", {24'b0, rd_cnt}, 32'd0);
    chk("midrst_ren", {31'b0, fifo_ren}, 32'd0);
    exp_q.delete();
    model_cnt = '0;
    @(posedge rclk); #1;
    rst_i = 1'b0; en = 1'b1; m_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge rclk);
      if (m_valid) begin
        found = 1'b1;
        chk("post_rst_data", {28'b0, m_data}, 32'd12);
        break;
      end
    end
    chk("post_rst_found", {31'b0, found}, 32'd1);

    // Randomized traffic with shifting biases.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int phase;
      phase = (i / 250) % 4;
      @(posedge rclk); #1;
      en      = ($urandom_range(0, 3) != 0) || (phase == 0);
      m_ready = (phase == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0 && (wr_ptr - rd_ptr) < 4000) push(DW'($urandom));
    end

    // Drain everything and confirm nothing was lost.
    @(posedge rclk); #1;
    en = 1'b1; m_ready = 1'b1;
    limit = (wr_ptr - rd_ptr) + 50;
    done = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge rclk);
      if (fifo_empty && exp_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain_done", {31'b0, done}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
